// File: rtl/dsp_add_arbiter_if.sv
// dsp_add_arbiter_if: requester handshake, adder port and response bundle for dsp_add_arbiter
interface dsp_add_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  hold;
  logic                  add_en;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_y;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_y;
  logic                  busy;
  modport master (
    output req_valid, req_a, req_b, hold, add_y,
    input  req_ready, add_en, add_a, add_b, rsp_valid, rsp_y, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, hold, add_y,
    output req_ready, add_en, add_a, add_b, rsp_valid, rsp_y, busy
  );
endinterface

// File: rtl/dsp_add_arbiter.sv
// dsp_add_arbiter: round-robin issue of requester operand pairs into one shared pipelined adder
module dsp_add_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int LATENCY = 1
) (
  input logic               clock,
  input logic               reset,
  dsp_add_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           win;
  logic                    found;
  logic                    grant;
  logic [PW:0]             idx;
  logic [2*NREQ-1:0]       rot;
  logic [WIDTH-1:0]        sel_a;
  logic [WIDTH-1:0]        sel_b;
  logic                    iss_v;
  logic [PW-1:0]           iss_id;
  logic [WIDTH-1:0]        add_a;
  logic [WIDTH-1:0]        add_b;
  logic [LATENCY-1:0]      tag_v;
  logic [LATENCY-1:0][PW-1:0] tag_id;
  logic [NREQ-1:0]         rsp_valid;
  logic [WIDTH-1:0]        rsp_y;
  // rot[k] is the request k positions after ptr, so the first set bit is the winner
  always_comb begin
    rot   = {bus.req_valid, bus.req_valid} >> ptr;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      idx = idx >= (PW+1)'(NREQ) ? idx - (PW+1)'(NREQ) : idx;
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    grant = found && !bus.hold;
  end
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        sel_a = bus.req_a[i*WIDTH +: WIDTH];
        sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      iss_v  <= 1'b0;
      iss_id <= '0;
      add_a  <= '0;
      add_b  <= '0;
    end else begin
      iss_v <= grant;
      if (grant) begin
        ptr    <= win == PW'(NREQ-1) ? '0 : win + PW'(1);
        iss_id <= win;
        add_a  <= sel_a;
        add_b  <= sel_b;
      end
    end
  end
  // the issue register acts as tag stage zero; the last stage lines up with add_y
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      for (int s = LATENCY-1; s > 0; s--) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      tag_v[0]  <= iss_v;
      tag_id[0] <= iss_id;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      rsp_valid <= tag_v[LATENCY-1] ? NREQ'(1) << tag_id[LATENCY-1] : '0;
      if (tag_v[LATENCY-1]) rsp_y <= bus.add_y;
    end
  end
  assign bus.req_ready = grant ? NREQ'(1) << win : '0;
  assign bus.add_en    = iss_v;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y;
  assign bus.busy      = iss_v | (|tag_v) | (|rsp_valid);
endmodule

// File: tb/tb_dsp_add_arbiter.sv
// tb_dsp_add_arbiter: directed checks of grant order, latency, hold, wrap, overflow and reset
module tb_dsp_add_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 1;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total  = 0;
  dsp_add_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
  dsp_add_arbiter #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );
  always #5 clock = ~clock;
  // single-register adder, LATENCY = 1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bus.add_y <= '0;
    else bus.add_y <= bus.add_a + bus.add_b;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic setop(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_add_en"}, 32'(bus.add_en), 0);
    chk({tag, "_add_a"}, 32'(bus.add_a), 0);
    chk({tag, "_add_b"}, 32'(bus.add_b), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_y"}, 32'(bus.rsp_y), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.hold      = 1'b0;
    #2;
    chk_zero("reset");
    tick;
    tick;
    reset = 1'b1;
    // single request from requester 2
    setop(2, 8'd5, 8'd7);
    bus.req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(bus.req_ready), 4'b0100);
    chk("single_busy0", 32'(bus.busy), 0);
    tick;
    bus.req_valid = '0;
    #1;
    chk("single_add_en", 32'(bus.add_en), 1);
    chk("single_add_a", 32'(bus.add_a), 5);
    chk("single_add_b", 32'(bus.add_b), 7);
    chk("single_busy1", 32'(bus.busy), 1);
    tick;
    chk("single_rsp_early", 32'(bus.rsp_valid), 0);
    tick;
    chk("single_rsp_valid", 32'(bus.rsp_valid), 4'b0100);
    chk("single_rsp_y", 32'(bus.rsp_y), 12);
    tick;
    chk("single_rsp_clear", 32'(bus.rsp_valid), 0);
    chk("single_busy_end", 32'(bus.busy), 0);
    chk("single_rsp_hold", 32'(bus.rsp_y), 12);
    // contention from reset
    reset = 1'b0;
    tick;
    reset = 1'b1;
    for (int i = 0; i < N; i++) setop(i, W'(i), 8'd10);
    bus.req_valid = 4'b1111;
    #1;
    chk("cont_g0", 32'(bus.req_ready), 4'b0001);
    tick;
    chk("cont_g1", 32'(bus.req_ready), 4'b0010);
    chk("cont_add_a0", 32'(bus.add_a), 0);
    chk("cont_add_b0", 32'(bus.add_b), 10);
    tick;
    chk("cont_g2", 32'(bus.req_ready), 4'b0100);
    chk("cont_add_a1", 32'(bus.add_a), 1);
    tick;
    chk("cont_g3", 32'(bus.req_ready), 4'b1000);
    chk("cont_rv0", 32'(bus.rsp_valid), 4'b0001);
    chk("cont_ry0", 32'(bus.rsp_y), 10);
    tick;
    chk("cont_g4", 32'(bus.req_ready), 4'b0001);
    chk("cont_rv1", 32'(bus.rsp_valid), 4'b0010);
    chk("cont_ry1", 32'(bus.rsp_y), 11);
    tick;
    bus.req_valid = '0;
    #1;
    chk("cont_rv2", 32'(bus.rsp_valid), 4'b0100);
    chk("cont_ry2", 32'(bus.rsp_y), 12);
    tick;
    chk("cont_rv3", 32'(bus.rsp_valid), 4'b1000);
    chk("cont_ry3", 32'(bus.rsp_y), 13);
    tick;
    chk("cont_rv4", 32'(bus.rsp_valid), 4'b0001);
    chk("cont_ry4", 32'(bus.rsp_y), 10);
    tick;
    tick;
    // wrap and skip, ptr is 1 here
    bus.req_valid = 4'b0100;
    #1;
    chk("wrap_pre", 32'(bus.req_ready), 4'b0100);
    tick;
    bus.req_valid = 4'b1010;
    #1;
    chk("wrap_g3a", 32'(bus.req_ready), 4'b1000);
    tick;
    chk("wrap_g1", 32'(bus.req_ready), 4'b0010);
    tick;
    chk("wrap_g3b", 32'(bus.req_ready), 4'b1000);
    tick;
    bus.req_valid = 4'b1111;
    #1;
    chk("wrap_ptr0", 32'(bus.req_ready), 4'b0001);
    bus.req_valid = '0;
    repeat (4) tick;
    // hold with two operations in flight
    setop(0, 8'd1, 8'd2);
    setop(1, 8'd3, 8'd4);
    bus.req_valid = 4'b0011;
    #1;
    chk("hold_g0", 32'(bus.req_ready), 4'b0001);
    tick;
    chk("hold_g1", 32'(bus.req_ready), 4'b0010);
    tick;
    bus.hold      = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("hold_ready0", 32'(bus.req_ready), 0);
    chk("hold_add_en", 32'(bus.add_en), 1);
    chk("hold_add_a", 32'(bus.add_a), 3);
    chk("hold_add_b", 32'(bus.add_b), 4);
    tick;
    chk("hold_ready1", 32'(bus.req_ready), 0);
    chk("hold_rv0", 32'(bus.rsp_valid), 4'b0001);
    chk("hold_ry0", 32'(bus.rsp_y), 3);
    tick;
    chk("hold_ready2", 32'(bus.req_ready), 0);
    chk("hold_rv1", 32'(bus.rsp_valid), 4'b0010);
    chk("hold_ry1", 32'(bus.rsp_y), 7);
    chk("hold_busy", 32'(bus.busy), 1);
    tick;
    bus.hold = 1'b0;
    #1;
    chk("hold_busy_end", 32'(bus.busy), 0);
    chk("hold_rv_end", 32'(bus.rsp_valid), 0);
    chk("hold_ptr_frozen", 32'(bus.req_ready), 4'b0100);
    bus.req_valid = '0;
    // overflow wraps modulo 2^WIDTH
    setop(2, 8'd200, 8'd100);
    bus.req_valid = 4'b0100;
    #1;
    chk("ovf_ready", 32'(bus.req_ready), 4'b0100);
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    chk("ovf_rv", 32'(bus.rsp_valid), 4'b0100);
    chk("ovf_ry", 32'(bus.rsp_y), 44);
    // reset with three operations in flight, ptr is 3 here
    for (int i = 0; i < N; i++) setop(i, W'(i), 8'd1);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_g3", 32'(bus.req_ready), 4'b1000);
    tick;
    chk("rst_g0", 32'(bus.req_ready), 4'b0001);
    tick;
    tick;
    chk("rst_inflight_rv", 32'(bus.rsp_valid), 4'b1000);
    chk("rst_inflight_busy", 32'(bus.busy), 1);
    bus.req_valid = '0;
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    tick;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("post_rst_rv", 32'(bus.rsp_valid), 0);
      chk("post_rst_busy", 32'(bus.busy), 0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("post_rst_g0", 32'(bus.req_ready), 4'b0001);
    bus.req_valid = '0;
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
